img_box_downscaler: RTL and testbench

Parametrised streaming box-filter downscaler, successor to the frame-buffered resizer. It takes a raster-order pixel stream with any number of channels and runtime power-of-two scale factors per axis, and selects either averaging or decimation. Each resized pixel is emitted as soon as its block completes, through a small output FIFO. A full resized frame is never held. The block sits between the pixel source and any resized-pixel consumer, and uses the same valid/ready stream convention on both sides.

---
 rtl/img_box_downscaler_pkg.sv | 14 +
 rtl/img_rsz_out_fifo.sv | 60 ++++++
 rtl/img_box_downscaler.sv | 195 +++++++++++++++++++
 tb/tb_img_box_downscaler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_box_downscaler_pkg.sv
// Shared types and helpers for the streaming box-filter downscaler.
package ImgRszPkg;

    typedef enum logic {
        RSZ_MODE_AVG = 1'b0,
        RSZ_MODE_DEC = 1'b1
    } rsz_mode_e;

    // Worst-case block sum: 2^SH_MAX * 2^SH_MAX pixels of pxl_w bits.
    function automatic int rsz_acc_width(input int pxl_w, input int sh_max);
        return pxl_w + 2 * sh_max;
    endfunction

endpackage

// File: rtl/img_rsz_out_fifo.sv
// Synchronous first-word-fallthrough FIFO whose head entry sits in a dedicated register.
module img_rsz_out_fifo #(
    parameter type T               = logic [7:0],
    parameter int  DEPTH           = 4,
    localparam int CNT_W           = $clog2(DEPTH + 1),
    localparam int PW              = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  T                 push_data_i,
    input  logic             rd_rdy_i,
    output logic             vld_o,
    output T                 data_o,
    output logic [CNT_W-1:0] cnt_o
);

    T                 mem_q [DEPTH];
    T                 head_q, head_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop, do_push;

    always_comb begin
        pop     = rd_rdy_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop);
        rd_nxt  = rd_ptr_q + PW'(1);
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(pop);
        head_d  = head_q;
        // The head register must always mirror the oldest live entry.
        if (do_push && ((cnt_q == '0) || (pop && (cnt_q == CNT_W'(1))))) begin
            head_d = push_data_i;
        end else if (pop && (cnt_q > CNT_W'(1))) begin
            head_d = mem_q[rd_nxt];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign vld_o  = (cnt_q != '0);
    assign data_o = head_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/img_box_downscaler.sv
// Streaming power-of-two box downscaler (average or decimate) with a one-line accumulator
// and a small FWFT output FIFO.
module img_box_downscaler
    import ImgRszPkg::*;
#(
    parameter int  PXL_W            = 8,
    parameter int  CH_NUM           = 3,
    parameter int  IMG_W_MAX        = 1024,
    parameter int  IMG_H_MAX        = 1024,
    parameter int  SH_MAX           = 3,
    parameter int  FIFO_DEPTH       = 4,
    localparam int IMG_WIDTH_IDX_W  = $clog2(IMG_W_MAX),
    localparam int IMG_HEIGHT_IDX_W = $clog2(IMG_H_MAX),
    localparam int SH_W             = $clog2(SH_MAX + 1)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [IMG_WIDTH_IDX_W-1:0]  ImgWidth,
    input  logic [IMG_HEIGHT_IDX_W-1:0] ImgHeight,
    input  logic [SH_W-1:0]             ShX,
    input  logic [SH_W-1:0]             ShY,
    input  logic                        Mode,
    input  logic [PXL_W-1:0]            PxlData [CH_NUM-1:0],
    input  logic [IMG_WIDTH_IDX_W-1:0]  PxlX,
    input  logic [IMG_HEIGHT_IDX_W-1:0] PxlY,
    input  logic                        PxlVld,
    output logic                        PxlRdy,
    output logic [PXL_W-1:0]            RszPxlData [CH_NUM-1:0],
    output logic [IMG_WIDTH_IDX_W-1:0]  RszPxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0] RszPxlY,
    output logic                        RszPxlLast,
    output logic                        RszPxlVld,
    input  logic                        RszPxlRdy,
    output logic [IMG_WIDTH_IDX_W-1:0]  RszImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0] RszImgHeight,
    output logic                        SeqErr
);

    localparam int XW    = IMG_WIDTH_IDX_W;
    localparam int YW    = IMG_HEIGHT_IDX_W;
    localparam int ACC_W = rsz_acc_width(PXL_W, SH_MAX);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [CH_NUM-1:0][PXL_W-1:0] data;
        logic [XW-1:0]                x;
        logic [YW-1:0]                y;
        logic                         last;
    } rsz_entry_t;

    function automatic logic [PXL_W-1:0] avg_round(input logic [ACC_W-1:0] sum,
                                                   input logic [SH_W:0]    s);
        logic [ACC_W:0] t;
        t = {1'b0, sum};
        if (s != '0) t = (t + ((ACC_W + 1)'(1) << (s - 1'b1))) >> s;
        return t[PXL_W-1:0];
    endfunction

    logic [XW-1:0]    cx_q, cx_d, w_q, outw_q;
    logic [YW-1:0]    cy_q, cy_d, h_q, outh_q;
    logic [SH_W-1:0]  shx_q, shy_q;
    rsz_mode_e        mode_q;
    logic             seq_err_q, seq_err_d;

    logic [XW-1:0]    cfg_w, cfg_outw, mx, blk_x;
    logic [YW-1:0]    cfg_h, cfg_outh, my, blk_y;
    logic [SH_W-1:0]  cfg_shx, cfg_shy;
    logic [SH_W:0]    sh_sum;
    rsz_mode_e        cfg_mode;
    logic             hs, frm_start, x_wrap, y_wrap;
    logic             blk_first, blk_last, in_crop, acc_we, push;

    logic [ACC_W-1:0] acc_q   [IMG_W_MAX][CH_NUM];
    logic [ACC_W-1:0] acc_old [CH_NUM];
    logic [ACC_W-1:0] acc_d   [CH_NUM];
    rsz_entry_t       push_entry, head;
    logic [CNT_W-1:0] fifo_cnt;

    assign PxlRdy = !Reset && (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign hs     = PxlVld && PxlRdy;

    always_comb begin
        // The (0,0) pixel itself already uses the configuration presented with it.
        frm_start = (cx_q == '0) && (cy_q == '0);
        cfg_w     = frm_start ? ImgWidth  : w_q;
        cfg_h     = frm_start ? ImgHeight : h_q;
        cfg_shx   = frm_start ? ShX       : shx_q;
        cfg_shy   = frm_start ? ShY       : shy_q;
        cfg_mode  = frm_start ? rsz_mode_e'(Mode) : mode_q;
        cfg_outw  = cfg_w >> cfg_shx;
        cfg_outh  = cfg_h >> cfg_shy;
        sh_sum    = {1'b0, cfg_shx} + {1'b0, cfg_shy};

        x_wrap = ({1'b0, cx_q} + (XW + 1)'(1)) >= {1'b0, cfg_w};
        y_wrap = ({1'b0, cy_q} + (YW + 1)'(1)) >= {1'b0, cfg_h};
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (hs) begin
            if (x_wrap) begin
                cx_d = '0;
                cy_d = y_wrap ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
        seq_err_d = seq_err_q || (hs && ((PxlX != cx_q) || (PxlY != cy_q)));

        mx        = ~({XW{1'b1}} << cfg_shx);
        my        = ~({YW{1'b1}} << cfg_shy);
        blk_first = ((cx_q & mx) == '0) && ((cy_q & my) == '0);
        blk_last  = ((cx_q & mx) == mx) && ((cy_q & my) == my);
        in_crop   = ({1'b0, cx_q} < ({1'b0, cfg_outw} << cfg_shx)) &&
                    ({1'b0, cy_q} < ({1'b0, cfg_outh} << cfg_shy));
        blk_x     = cx_q >> cfg_shx;
        blk_y     = cy_q >> cfg_shy;

        // Decimation keeps the top-left pixel, so only the block's first pixel is written.
        acc_we = hs && in_crop && (blk_first || (cfg_mode == RSZ_MODE_AVG));
        push   = hs && in_crop && blk_last;

        push_entry      = '0;
        push_entry.x    = blk_x;
        push_entry.y    = blk_y;
        push_entry.last = (blk_x == cfg_outw - XW'(1)) && (blk_y == cfg_outh - YW'(1));
        for (int c = 0; c < CH_NUM; c++) begin
            acc_old[c] = acc_q[blk_x][c];
            acc_d[c]   = blk_first ? ACC_W'(PxlData[c]) : acc_old[c] + ACC_W'(PxlData[c]);
            if (cfg_mode == RSZ_MODE_DEC) begin
                push_entry.data[c] = blk_first ? PxlData[c] : acc_old[c][PXL_W-1:0];
            end else begin
                push_entry.data[c] = avg_round(acc_d[c], sh_sum);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cx_q      <= '0;
            cy_q      <= '0;
            seq_err_q <= 1'b0;
            w_q       <= '0;
            h_q       <= '0;
            shx_q     <= '0;
            shy_q     <= '0;
            mode_q    <= RSZ_MODE_AVG;
            outw_q    <= '0;
            outh_q    <= '0;
        end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            seq_err_q <= seq_err_d;
            if (hs && frm_start) begin
                w_q    <= cfg_w;
                h_q    <= cfg_h;
                shx_q  <= cfg_shx;
                shy_q  <= cfg_shy;
                mode_q <= cfg_mode;
                outw_q <= cfg_outw;
                outh_q <= cfg_outh;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (acc_we) begin
            for (int c = 0; c < CH_NUM; c++) acc_q[blk_x][c] <= acc_d[c];
        end
    end

    img_rsz_out_fifo #(
        .T     (rsz_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .rd_rdy_i    (RszPxlRdy),
        .vld_o       (RszPxlVld),
        .data_o      (head),
        .cnt_o       (fifo_cnt)
    );

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) RszPxlData[c] = head.data[c];
    end

    assign RszPxlX      = head.x;
    assign RszPxlY      = head.y;
    assign RszPxlLast   = head.last;
    assign RszImgWidth  = outw_q;
    assign RszImgHeight = outh_q;
    assign SeqErr       = seq_err_q;

endmodule

// File: tb/tb_img_box_downscaler.sv
// Bench for img_box_downscaler: vector table of frames plus stall, sequence-error and reset sequences.
module tb_img_box_downscaler;

    localparam int PXL_W = 8;
    localparam int CH    = 3;
    localparam int XW    = 10;
    localparam int YW    = 10;
    localparam int SH_W  = 2;
    localparam int MAXW  = 136;
    localparam int MAXH  = 72;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [XW-1:0]     ImgWidth, PxlX, RszPxlX, RszImgWidth;
    logic [YW-1:0]     ImgHeight, PxlY, RszPxlY, RszImgHeight;
    logic [SH_W-1:0]   ShX, ShY;
    logic              Mode, PxlVld, PxlRdy, RszPxlLast, RszPxlVld, RszPxlRdy, SeqErr;
    logic [PXL_W-1:0]  PxlData    [CH-1:0];
    logic [PXL_W-1:0]  RszPxlData [CH-1:0];

    always #5 Clk = ~Clk;

    img_box_downscaler dut (
        .Clk(Clk), .Reset(Reset), .ImgWidth(ImgWidth), .ImgHeight(ImgHeight),
        .ShX(ShX), .ShY(ShY), .Mode(Mode), .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY),
        .PxlVld(PxlVld), .PxlRdy(PxlRdy), .RszPxlData(RszPxlData), .RszPxlX(RszPxlX),
        .RszPxlY(RszPxlY), .RszPxlLast(RszPxlLast), .RszPxlVld(RszPxlVld),
        .RszPxlRdy(RszPxlRdy), .RszImgWidth(RszImgWidth), .RszImgHeight(RszImgHeight),
        .SeqErr(SeqErr)
    );

    typedef struct { int data; int x; int y; int last; } out_t;
    typedef struct { int w; int h; int shx; int shy; int mode; int ramp; int rmode;
                     int lat; int cnt; int first0; } vec_t;

    out_t got_q[$];
    out_t exp_q[$];
    int   img [MAXH][MAXW][CH];
    int   n_tests = 0, n_fail = 0;
    int   rdy_mode = 0;
    int   n_acc = 0;
    bit   drive_done;
    vec_t vecs [8];

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int pk_out();
        return int'({RszPxlData[2], RszPxlData[1], RszPxlData[0]});
    endfunction

    // Consumer: chooses its ready for the coming edge and logs what that edge will take.
    always @(negedge Clk) begin
        case (rdy_mode)
            0:       RszPxlRdy = 1'b1;
            1:       RszPxlRdy = 1'($urandom_range(0, 1));
            default: RszPxlRdy = 1'b0;
        endcase
        if (RszPxlVld && RszPxlRdy)
            got_q.push_back('{pk_out(), int'(RszPxlX), int'(RszPxlY), int'(RszPxlLast)});
    end

    task automatic gen_img(input int w, input int h, input int ramp);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                for (int c = 0; c < CH; c++)
                    img[y][x][c] = ramp ? ((x + 8 * y + 37 * c) & 255) : int'($urandom_range(0, 255));
    endtask

    // Reference: every complete block in raster order, averaged with round-half-up or decimated.
    task automatic build_exp(input int w, input int h, input int shx, input int shy, input int mode);
        int ow, oh, bw, bh, s, sum, v, d;
        exp_q.delete();
        ow = w >> shx; oh = h >> shy; bw = 1 << shx; bh = 1 << shy; s = shx + shy;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                d = 0;
                for (int c = 0; c < CH; c++) begin
                    if (mode != 0) begin
                        v = img[oy * bh][ox * bw][c];
                    end else begin
                        sum = 0;
                        for (int j = 0; j < bh; j++)
                            for (int i = 0; i < bw; i++) sum += img[oy * bh + j][ox * bw + i][c];
                        v = (s == 0) ? sum : (sum + (1 << (s - 1))) >> s;
                    end
                    d |= v << (8 * c);
                end
                exp_q.push_back('{d, ox, oy, int'(ox == ow - 1 && oy == oh - 1)});
            end
    endtask

    task automatic drive_frame(input int w, input int h, input int shx, input int shy,
                               input int mode, input int skip, input int lat, input int n_max);
        int idx, guard, pv;
        ImgWidth = XW'(w); ImgHeight = YW'(h);
        ShX = SH_W'(shx); ShY = SH_W'(shy); Mode = mode[0];
        @(negedge Clk);
        idx = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (idx == n_max) begin PxlVld = 1'b0; return; end
                PxlVld = 1'b1;
                PxlX = XW'((idx == skip) ? x + 1 : x);
                PxlY = YW'(y);
                for (int c = 0; c < CH; c++) PxlData[c] = PXL_W'(img[y][x][c]);
                pv = img[y][x][0] | (img[y][x][1] << 8) | (img[y][x][2] << 16);
                if (idx == skip) chk("seqerr_before_skip", int'(SeqErr), 0);
                guard = 0;
                while (!PxlRdy && guard < 3000) begin @(negedge Clk); guard++; end
                if (guard >= 3000) begin
                    chk("pxlrdy_timeout", 0, 1);
                    PxlVld = 1'b0;
                    return;
                end
                @(posedge Clk);
                n_acc++;
                @(negedge Clk);
                if (lat != 0) begin
                    chk("lat_vld", int'(RszPxlVld), 1);
                    chk("lat_data", pk_out(), pv);
                end
                if (skip >= 0 && idx >= skip) chk("seqerr_sticky", int'(SeqErr), 1);
                idx++;
            end
        PxlVld = 1'b0;
    endtask

    task automatic check_frame(input int w, input int h, input int shx, input int shy,
                               input int exp_cnt, input int first0, input string name);
        int guard, n;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 2000) begin @(negedge Clk); guard++; end
        repeat (8) @(negedge Clk);
        chk({name, "_count"}, got_q.size(), exp_cnt);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_data"}, got_q[i].data, exp_q[i].data);
            chk({name, "_xy"}, got_q[i].x * 4096 + got_q[i].y, exp_q[i].x * 4096 + exp_q[i].y);
            chk({name, "_last"}, got_q[i].last, exp_q[i].last);
        end
        if (first0 >= 0 && got_q.size() > 0) chk({name, "_first_ch0"}, got_q[0].data & 255, first0);
        chk({name, "_outw"}, int'(RszImgWidth), w >> shx);
        chk({name, "_outh"}, int'(RszImgHeight), h >> shy);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_pxlrdy"}, int'(PxlRdy), 0);
        chk({name, "_vld"}, int'(RszPxlVld), 0);
        chk({name, "_data"}, pk_out(), 0);
        chk({name, "_xy"}, int'(RszPxlX) + int'(RszPxlY), 0);
        chk({name, "_last"}, int'(RszPxlLast), 0);
        chk({name, "_dims"}, int'(RszImgWidth) + int'(RszImgHeight), 0);
        chk({name, "_seqerr"}, int'(SeqErr), 0);
    endtask

    initial begin
        int g;
        vecs[0] = '{8,   4,  1, 1, 0, 1, 0, 0, 8,    5};
        vecs[1] = '{129, 65, 2, 1, 1, 1, 0, 0, 1024, 0};
        vecs[2] = '{5,   3,  0, 0, 0, 0, 0, 1, 15,  -1};
        vecs[3] = '{3,   4,  2, 0, 0, 0, 0, 0, 0,   -1};
        vecs[4] = '{16,  8,  3, 3, 0, 0, 1, 0, 2,   -1};
        vecs[5] = '{12,  10, 2, 1, 1, 0, 1, 0, 15,  -1};
        vecs[6] = '{20,  12, 1, 2, 0, 0, 1, 0, 30,  -1};
        vecs[7] = '{9,   7,  3, 2, 0, 0, 0, 0, 1,   -1};

        Reset = 1'b1; PxlVld = 1'b0; PxlX = '0; PxlY = '0; Mode = 1'b0;
        ImgWidth = '0; ImgHeight = '0; ShX = '0; ShY = '0;
        for (int c = 0; c < CH; c++) PxlData[c] = '0;
        repeat (3) @(negedge Clk);
        check_reset("rst0");
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst0_pxlrdy_after", int'(PxlRdy), 1);

        for (int i = 0; i < 8; i++) begin
            gen_img(vecs[i].w, vecs[i].h, vecs[i].ramp);
            build_exp(vecs[i].w, vecs[i].h, vecs[i].shx, vecs[i].shy, vecs[i].mode);
            got_q.delete();
            rdy_mode = vecs[i].rmode;
            drive_frame(vecs[i].w, vecs[i].h, vecs[i].shx, vecs[i].shy, vecs[i].mode,
                        -1, vecs[i].lat, -1);
            check_frame(vecs[i].w, vecs[i].h, vecs[i].shx, vecs[i].shy,
                        vecs[i].cnt, vecs[i].first0, $sformatf("vec%0d", i));
            rdy_mode = 0;
        end

        // Consumer stalled: input must stop once the FIFO holds FIFO_DEPTH results.
        gen_img(8, 4, 0);
        build_exp(8, 4, 1, 1, 0);
        got_q.delete();
        n_acc = 0;
        drive_done = 1'b0;
        rdy_mode = 2;
        fork
            begin
                drive_frame(8, 4, 1, 1, 0, -1, 0, -1);
                drive_done = 1'b1;
            end
        join_none
        repeat (60) @(negedge Clk);
        chk("stall_pxlrdy", int'(PxlRdy), 0);
        chk("stall_accepted", n_acc, 16);
        chk("stall_vld", int'(RszPxlVld), 1);
        chk("stall_taken", got_q.size(), 0);
        rdy_mode = 0;
        g = 0;
        while (!drive_done && g < 4000) begin @(negedge Clk); g++; end
        chk("stall_drive_done", int'(drive_done), 1);
        check_frame(8, 4, 1, 1, 8, -1, "stall");

        // Reported column skips ahead once; data still lands at the internal position.
        gen_img(8, 4, 0);
        build_exp(8, 4, 1, 1, 0);
        got_q.delete();
        drive_frame(8, 4, 1, 1, 0, 3, 0, -1);
        check_frame(8, 4, 1, 1, 8, -1, "seqerr");

        // Abort a frame mid-way, then a fresh 4x4 frame must come out clean.
        gen_img(8, 4, 0);
        drive_frame(8, 4, 1, 1, 0, -1, 0, 10);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset("rst_mid");
        Reset = 1'b0;
        got_q.delete();
        gen_img(4, 4, 0);
        build_exp(4, 4, 1, 1, 0);
        drive_frame(4, 4, 1, 1, 0, -1, 0, -1);
        check_frame(4, 4, 1, 1, 4, -1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
